// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the BCD stopwatch: digit limits, preset clamp, default tick divider.
package stopwatch_pkg;

  localparam logic [3:0]  MOD10_MAX        = 4'd9;
  localparam logic [3:0]  MOD6_MAX         = 4'd5;
  localparam int unsigned DEFAULT_TICK_DIV = 500000;

  // Saturate each nibble of a packed {tens, units} value into the 00-59 range.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (v[7:4] > MOD6_MAX)  ? MOD6_MAX  : v[7:4];
    units = (v[3:0] > MOD10_MAX) ? MOD10_MAX : v[3:0];
    return {tens, units};
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control triple from the keypad controller and BCD time outputs toward the display mux.
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic       clr_n;
  logic       en;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic [7:0] min;
  logic [7:0] sec;
  logic [7:0] cs;
  logic       tick;
  logic       wrap;
  logic       running;

  modport master (
    output clr_n, en, load, load_min, load_sec,
    input  min, sec, cs, tick, wrap, running
  );

  modport slave (
    input  clr_n, en, load, load_min, load_sec,
    output min, sec, cs, tick, wrap, running
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of the chain: counts 0..MAX, carry is combinational so the chain settles within a tick.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = MOD10_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc & (q == MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS.CC stopwatch: centisecond prescaler, clear/load/count priority decode and a six-digit BCD chain.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned PW       = 19
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_counter_if.slave  bus
);

  logic [PW-1:0] presc;
  logic          tick_q;
  logic          wrap_q;
  logic          running_q;

  logic       clr;
  logic       ld;
  logic       cnt;
  logic       expire;
  logic       tick_nxt;
  logic [7:0] ld_min;
  logic [7:0] ld_sec;

  logic [3:0] cs_u, cs_t, sec_u, sec_t, min_u, min_t;
  logic       c_cs_u, c_cs_t, c_sec_u, c_sec_t, c_min_u, c_min_t;

  // Priority: clear > load > count > hold.
  assign clr      = ~bus.clr_n;
  assign ld       = bus.clr_n & bus.load;
  assign cnt      = bus.clr_n & ~bus.load & bus.en;
  assign expire   = (presc == PW'(TICK_DIV - 1));
  assign tick_nxt = cnt & expire;
  assign ld_min   = clamp_bcd(bus.load_min);
  assign ld_sec   = clamp_bcd(bus.load_sec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_q    <= tick_nxt;
      wrap_q    <= c_min_t;
      running_q <= bus.en & bus.clr_n & ~bus.load;
      if (clr || ld) begin
        presc <= '0;
      end else if (cnt) begin
        presc <= expire ? '0 : presc + PW'(1);
      end
    end
  end

  bcd_digit #(.MAX(MOD10_MAX)) u_cs_u (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(4'd0),
    .inc(tick_nxt), .q(cs_u), .carry(c_cs_u)
  );
  bcd_digit #(.MAX(MOD10_MAX)) u_cs_t (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(4'd0),
    .inc(c_cs_u), .q(cs_t), .carry(c_cs_t)
  );
  bcd_digit #(.MAX(MOD10_MAX)) u_sec_u (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_sec[3:0]),
    .inc(c_cs_t), .q(sec_u), .carry(c_sec_u)
  );
  bcd_digit #(.MAX(MOD6_MAX)) u_sec_t (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_sec[7:4]),
    .inc(c_sec_u), .q(sec_t), .carry(c_sec_t)
  );
  bcd_digit #(.MAX(MOD10_MAX)) u_min_u (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_min[3:0]),
    .inc(c_sec_t), .q(min_u), .carry(c_min_u)
  );
  // Carry out of the top digit is exactly the 59:59.99 -> 00:00.00 rollover.
  bcd_digit #(.MAX(MOD6_MAX)) u_min_t (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_min[7:4]),
    .inc(c_min_u), .q(min_t), .carry(c_min_t)
  );

  assign bus.min     = {min_t, min_u};
  assign bus.sec     = {sec_t, sec_u};
  assign bus.cs      = {cs_t, cs_u};
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter with TICK_DIV=4: integer time model feeding a scoreboard queue.
module tb_stopwatch_counter;

  localparam int unsigned TD = 4;
  localparam int unsigned PW = 3;
  localparam int          T_MAX = 59*6000 + 59*100 + 99;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cs;
    logic       tick;
    logic       wrap;
    logic       running;
  } obs_t;

  typedef struct {
    logic [7:0] lmin;
    logic [7:0] lsec;
    logic [7:0] exp_min;
    logic [7:0] exp_sec;
  } clamp_vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_counter_if bus();

  stopwatch_counter #(.TICK_DIV(TD), .PW(PW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: elapsed centiseconds as one integer plus prescaler phase.
  int   m_t;
  int   m_p;
  logic m_tick, m_wrap, m_run;

  obs_t sb[$];
  int   cyc, ticks, wraps, first_tick, last_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_int(input logic [7:0] b);
    int tn, un;
    tn = (int'(b[7:4]) > 5) ? 5 : int'(b[7:4]);
    un = (int'(b[3:0]) > 9) ? 9 : int'(b[3:0]);
    return tn * 10 + un;
  endfunction

  task automatic model_reset();
    m_t = 0; m_p = 0; m_tick = 1'b0; m_wrap = 1'b0; m_run = 1'b0;
  endtask

  task automatic win_start();
    cyc = 0; ticks = 0; wraps = 0; first_tick = -1; last_wrap = -1;
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare after the edge.
  task automatic step(input logic c, input logic e, input logic l,
                      input logic [7:0] lm, input logic [7:0] ls);
    obs_t exp_o, got;
    bus.clr_n = c; bus.en = e; bus.load = l; bus.load_min = lm; bus.load_sec = ls;
    m_tick = 1'b0; m_wrap = 1'b0;
    m_run  = e & c & ~l;
    if (!c) begin
      m_t = 0; m_p = 0;
    end else if (l) begin
      m_t = clamp_int(lm) * 6000 + clamp_int(ls) * 100; m_p = 0;
    end else if (e) begin
      if (m_p == int'(TD) - 1) begin
        m_p = 0; m_tick = 1'b1;
        if (m_t == T_MAX) begin m_t = 0; m_wrap = 1'b1; end
        else m_t = m_t + 1;
      end else begin
        m_p = m_p + 1;
      end
    end
    exp_o.min = to_bcd(m_t / 6000);
    exp_o.sec = to_bcd((m_t / 100) % 60);
    exp_o.cs  = to_bcd(m_t % 100);
    exp_o.tick = m_tick; exp_o.wrap = m_wrap; exp_o.running = m_run;
    sb.push_back(exp_o);
    @(posedge clk);
    #1;
    cyc++;
    got.min = bus.min; got.sec = bus.sec; got.cs = bus.cs;
    got.tick = bus.tick; got.wrap = bus.wrap; got.running = bus.running;
    exp_o = sb.pop_front();
    check("cycle_obs", 32'(got), 32'(exp_o));
    if (got.tick) begin
      ticks++;
      if (first_tick < 0) first_tick = cyc;
    end
    if (got.wrap) begin
      wraps++;
      last_wrap = cyc;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    clamp_vec_t cv[6];
    cv[0] = '{8'h7C, 8'h30, 8'h59, 8'h30};
    cv[1] = '{8'h05, 8'h42, 8'h05, 8'h42};
    cv[2] = '{8'hFF, 8'hFF, 8'h59, 8'h59};
    cv[3] = '{8'h0A, 8'h6B, 8'h09, 8'h59};
    cv[4] = '{8'h99, 8'h00, 8'h59, 8'h00};
    cv[5] = '{8'h50, 8'hA9, 8'h50, 8'h59};

    rst = 1'b1;
    bus.clr_n = 1'b1; bus.en = 1'b0; bus.load = 1'b0;
    bus.load_min = 8'h00; bus.load_sec = 8'h00;
    model_reset();
    win_start();
    repeat (2) @(posedge clk);
    #1;
    check("reset_time", {8'h0, bus.min, bus.sec, bus.cs}, 32'h0);
    check("reset_flags", {29'h0, bus.tick, bus.wrap, bus.running}, 32'h0);
    rst = 1'b0;

    // Async reset mid-count at 00:12.34
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h12);
    repeat (136) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("pre_reset_time", {8'h0, bus.min, bus.sec, bus.cs}, 32'h00001234);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_time", {8'h0, bus.min, bus.sec, bus.cs}, 32'h0);
    check("async_reset_tick", 32'(bus.tick), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Count 150 ticks from zero
    win_start();
    repeat (600) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("count_ticks", 32'(ticks), 32'd150);
    check("count_first_tick", 32'(first_tick), 32'd4);
    check("count_time", {8'h0, bus.min, bus.sec, bus.cs}, 32'h00000150);

    // Preset clamp table
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, cv[i].lmin, cv[i].lsec);
      check("clamp_load", {8'h0, bus.min, bus.sec, bus.cs},
            {8'h0, cv[i].exp_min, cv[i].exp_sec, 8'h00});
    end

    // Load held with en: load wins, no ticks
    step(1'b1, 1'b0, 1'b1, 8'h7C, 8'h30);
    win_start();
    repeat (20) step(1'b1, 1'b1, 1'b1, 8'h7C, 8'h30);
    check("load_en_ticks", 32'(ticks), 32'd0);
    check("load_en_time", {8'h0, bus.min, bus.sec, bus.cs}, 32'h00593000);

    // Wrap from 59:59.00 after 100 ticks
    step(1'b1, 1'b0, 1'b1, 8'h59, 8'h59);
    win_start();
    repeat (400) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("wrap_count", 32'(wraps), 32'd1);
    check("wrap_cycle", 32'(last_wrap), 32'd400);
    check("wrap_ticks", 32'(ticks), 32'd100);
    check("wrap_time", {8'h0, bus.min, bus.sec, bus.cs}, 32'h0);

    // Pause mid-tick keeps prescaler phase
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    win_start();
    repeat (6) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("pause_pre_cs", 32'(bus.cs), 32'h01);
    repeat (50) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("pause_hold_ticks", 32'(ticks), 32'd1);
    win_start();
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("resume_first_tick", 32'(first_tick), 32'd2);
    check("resume_cs", 32'(bus.cs), 32'h02);

    // en drops on the expiring cycle: no tick, phase held at TICK_DIV-1
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    win_start();
    repeat (5) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("expire_hold_ticks", 32'(ticks), 32'd0);
    win_start();
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    check("expire_resume_tick", 32'(first_tick), 32'd1);

    // Clear beats load and en, then a fresh preset
    repeat (20) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    repeat (3) begin
      step(1'b0, 1'b1, 1'b1, 8'h33, 8'h33);
      check("clear_prio_time", {8'h0, bus.min, bus.sec, bus.cs}, 32'h0);
    end
    step(1'b1, 1'b0, 1'b1, 8'h05, 8'h42);
    check("post_clear_load", {8'h0, bus.min, bus.sec, bus.cs}, 32'h00054200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
